// File: rtl/nibble_frame_unpacker.sv
// Receive-side nibble frame reassembler: one header nibble (sync bit + tag)
// followed by NIB payload nibbles, presented as a tagged record.
module nibble_frame_unpacker #(
    parameter int NIB = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_tag,
    output logic [4*NIB-1:0]   out_data,
    output logic               err
);

    localparam int CW = $clog2(NIB + 1);

    typedef enum logic [2:0] {
        T_A = 3'd2,
        T_B = 3'd3,
        T_C = 3'd4
    } tag_t;

    typedef logic [3:0] nibble_t;

    typedef struct packed {
        tag_t                  tag;
        nibble_t [NIB-1:0]     data;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    rec_t            rec_q, rec_d;
    logic            err_q, err_d;

    logic            accept;
    logic            hdr_sync;
    logic            hdr_ok;
    logic [4*NIB+3:0] shifted;

    assign in_ready = (state_q != HOLD) || out_ready;
    assign accept   = in_valid && in_ready;
    assign hdr_sync = in_data[3];
    assign hdr_ok   = hdr_sync && (in_data[2:0] inside {3'd2, 3'd3, 3'd4});
    // Concatenate-then-truncate keeps the shift legal for NIB=1.
    assign shifted  = {rec_q.data, in_data};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rec_d   = rec_q;
        err_d   = 1'b0;

        if (state_q == PAYLOAD) begin
            if (accept) begin
                rec_d.data = shifted[4*NIB-1:0];
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(NIB - 1)) begin
                    state_d = HOLD;
                end
            end
        end else begin
            if (state_q == HOLD && out_ready) begin
                state_d = IDLE;
            end
            // Header handling is shared by IDLE and the HOLD release cycle.
            if (accept && hdr_sync) begin
                if (hdr_ok) begin
                    state_d   = PAYLOAD;
                    cnt_d     = '0;
                    rec_d.tag = tag_t'(in_data[2:0]);
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rec_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rec_q   <= rec_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_tag   = rec_q.tag;
    assign out_data  = rec_q.data;
    assign err       = err_q;

endmodule

// File: tb/tb_nibble_frame_unpacker.sv
// Scoreboard bench for nibble_frame_unpacker at NIB = 4, 1 and 8.
module tb_nibble_frame_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid [3];
    logic [3:0]  in_data [3];
    logic        out_ready [3];
    logic        in_ready [3];
    logic        out_valid [3];
    logic [2:0]  out_tag [3];
    logic        err [3];
    logic [15:0] od4;
    logic [3:0]  od1;
    logic [31:0] od8;
    logic [31:0] odata [3];

    assign odata[0] = {16'h0, od4};
    assign odata[1] = {28'h0, od1};
    assign odata[2] = od8;

    nibble_frame_unpacker #(.NIB(4)) u_nib4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_tag(out_tag[0]), .out_data(od4), .err(err[0]));

    nibble_frame_unpacker #(.NIB(1)) u_nib1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_tag(out_tag[1]), .out_data(od1), .err(err[1]));

    nibble_frame_unpacker #(.NIB(8)) u_nib8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_tag(out_tag[2]), .out_data(od8), .err(err[2]));

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    int err_seen [3] = '{0, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (err[i] === 1'b1) err_seen[i] <= err_seen[i] + 1;
        end
    end

    typedef struct {
        logic [2:0]  tag;
        logic [31:0] data;
    } rec_t;

    rec_t exp_q[$];

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [3:0] n);
        int unsigned t = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = n;
        @(negedge clk);
        while (in_ready[d] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (in_ready[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut=%0d nibble=%h got in_ready=%b need 1", d, n, in_ready[d]);
        end
        align();
        in_valid[d] = 1'b0;
    endtask

    task automatic send_frame(input int d, input logic [3:0] hdr, input logic [31:0] p, input int nib);
        send(d, hdr);
        for (int i = nib - 1; i >= 0; i--) begin
            send(d, 4'(p >> (4 * i)));
        end
    endtask

    task automatic check_out(input int d, input int unsigned budget, output int unsigned fc);
        rec_t e;
        int unsigned t = 0;
        logic fired = 1'b0;
        fc = 0;
        while (!fired && t < budget) begin
            @(negedge clk);
            t++;
            if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) fired = 1'b1;
        end
        checks++;
        if (!fired) begin
            errors++;
            $display("FAIL record_timeout dut=%0d got no record need one within %0d cycles", d, budget);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL record_unexpected dut=%0d got tag=%0d data=%h need none", d, out_tag[d], odata[d]);
        end else begin
            e  = exp_q.pop_front();
            fc = cyc;
            if (out_tag[d] !== e.tag || odata[d] !== e.data) begin
                errors++;
                $display("FAIL record dut=%0d got tag=%0d data=%h need tag=%0d data=%h",
                         d, out_tag[d], odata[d], e.tag, e.data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) align();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut=%0d got %b need 1", d, in_ready[d]); end
            checks++;
            if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut=%0d got %b need 0", d, out_valid[d]); end
            checks++;
            if (out_tag[d] !== 3'd0) begin errors++; $display("FAIL reset_out_tag dut=%0d got %0d need 0", d, out_tag[d]); end
            checks++;
            if (odata[d] !== 32'h0) begin errors++; $display("FAIL reset_out_data dut=%0d got %h need 0", d, odata[d]); end
            checks++;
            if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut=%0d got %b need 0", d, err[d]); end
        end
        rst = 1'b0;
        align();
    endtask

    task automatic test_basic();
        int unsigned fc;
        int e0 = err_seen[0];
        exp_q.push_back('{tag: 3'd3, data: 32'h1234});
        send_frame(0, 4'hB, 32'h1234, 4);
        checks++;
        if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_latency got out_valid=%b need 1", out_valid[0]); end
        check_out(0, 3, fc);
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got out_valid=%b need 0", out_valid[0]); end
        align();
        checks++;
        if (err_seen[0] != e0) begin errors++; $display("FAIL basic_err got %0d pulses need 0", err_seen[0] - e0); end
    endtask

    task automatic test_backpressure();
        int unsigned fc;
        int unsigned c0;
        out_ready[0] = 1'b0;
        exp_q.push_back('{tag: 3'd2, data: 32'hF00D});
        exp_q.push_back('{tag: 3'd4, data: 32'h9ABC});
        send_frame(0, 4'hA, 32'hF00D, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b1 || out_tag[0] !== 3'd2 || odata[0] !== 32'hF00D || in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable got valid=%b tag=%0d data=%h in_ready=%b need 1 2 f00d 0",
                         out_valid[0], out_tag[0], odata[0], in_ready[0]);
            end
        end
        align();
        fork
            begin
                c0 = cyc;
                out_ready[0] = 1'b1;
                send(0, 4'hC);
                checks++;
                if (cyc != c0 + 1) begin errors++; $display("FAIL header_no_bubble got %0d cycles need 1", cyc - c0); end
                send(0, 4'h9);
                send(0, 4'hA);
                send(0, 4'hB);
                send(0, 4'hC);
            end
            begin
                check_out(0, 5, fc);
                check_out(0, 20, fc);
            end
        join
        align();
    endtask

    task automatic test_bad_tag();
        int unsigned fc;
        int e0 = err_seen[0];
        send(0, 4'h8);
        @(negedge clk);
        checks++;
        if (err[0] !== 1'b1) begin errors++; $display("FAIL err_timing got %b need 1", err[0]); end
        align();
        send(0, 4'h5);
        exp_q.push_back('{tag: 3'd3, data: 32'hABCD});
        send_frame(0, 4'hB, 32'hABCD, 4);
        check_out(0, 3, fc);
        align();
        checks++;
        if (err_seen[0] - e0 != 1) begin errors++; $display("FAIL err_count got %0d pulses need 1", err_seen[0] - e0); end
    endtask

    task automatic test_payload_bit3();
        int unsigned fc;
        int e0 = err_seen[0];
        exp_q.push_back('{tag: 3'd2, data: 32'h89EF});
        send_frame(0, 4'hA, 32'h89EF, 4);
        check_out(0, 3, fc);
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bit3_no_resync got out_valid=%b need 0", out_valid[0]); end
        align();
        checks++;
        if (err_seen[0] != e0) begin errors++; $display("FAIL bit3_err got %0d pulses need 0", err_seen[0] - e0); end
    endtask

    task automatic test_stall_reset();
        int unsigned fc;
        send(0, 4'hB);
        send(0, 4'h1);
        send(0, 4'h2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL stall got valid=%b in_ready=%b need 0 1", out_valid[0], in_ready[0]);
            end
        end
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_tag[0] !== 3'd0 || odata[0] !== 32'h0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset got in_ready=%b valid=%b tag=%0d data=%h err=%b need 1 0 0 0 0",
                     in_ready[0], out_valid[0], out_tag[0], odata[0], err[0]);
        end
        exp_q.push_back('{tag: 3'd4, data: 32'h5678});
        send_frame(0, 4'hC, 32'h5678, 4);
        check_out(0, 3, fc);
        align();
    endtask

    task automatic test_back_to_back();
        int unsigned f1, f2, f3;
        exp_q.push_back('{tag: 3'd2, data: 32'h7});
        send_frame(1, 4'hA, 32'h7, 1);
        check_out(1, 3, f1);
        align();

        exp_q.push_back('{tag: 3'd3, data: 32'h1});
        exp_q.push_back('{tag: 3'd4, data: 32'h2});
        exp_q.push_back('{tag: 3'd2, data: 32'h3});
        fork
            begin
                send_frame(1, 4'hB, 32'h1, 1);
                send_frame(1, 4'hC, 32'h2, 1);
                send_frame(1, 4'hA, 32'h3, 1);
            end
            begin
                check_out(1, 10, f1);
                check_out(1, 10, f2);
                check_out(1, 10, f3);
            end
        join
        checks++;
        if (f2 - f1 != 2 || f3 - f2 != 2) begin
            errors++;
            $display("FAIL rate_nib1 got spacing %0d,%0d need 2,2", f2 - f1, f3 - f2);
        end
        align();

        exp_q.push_back('{tag: 3'd3, data: 32'h12345678});
        exp_q.push_back('{tag: 3'd4, data: 32'h87654321});
        fork
            begin
                send_frame(2, 4'hB, 32'h12345678, 8);
                send_frame(2, 4'hC, 32'h87654321, 8);
            end
            begin
                check_out(2, 30, f1);
                check_out(2, 30, f2);
            end
        join
        checks++;
        if (f2 - f1 != 9) begin errors++; $display("FAIL rate_nib8 got spacing %0d need 9", f2 - f1); end
        align();
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = 4'h0;
            out_ready[d] = 1'b1;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_tag();
        test_payload_bit3();
        test_stall_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_records got %0d need 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_frame_unpacker.md
# nibble_frame_unpacker

- Receives a 4-bit nibble stream over a valid/ready handshake.
- Reassembles each frame (one header nibble, then `NIB` payload nibbles) into a packed output record: an enum-typed tag plus a payload word.
- This is the receive-side counterpart of the nibble frame packer. It sits between a narrow link interface and wide datapath consumers.
- Internally, the header tag is a module-scope enum typedef, the output record is a packed-struct typedef built on a 4-bit nibble typedef, and the FSM state is a separate enum typedef.

## Interface
Parameters:
- `NIB`, default 4: payload nibbles per frame. Range 1..8. The payload width is `4*NIB`.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_ready`, output, 1: the block accepts `in_data` this cycle.
- `in_data`, input, 4: nibble. A transfer occurs when `in_valid && in_ready`.
- `out_valid`, output, 1: the output record is valid.
- `out_ready`, input, 1: the consumer accepts the record. A transfer occurs when `out_valid && out_ready`.
- `out_tag`, output, 3: frame tag. Enum values are `T_A=2`, `T_B=3`, `T_C=4`.
- `out_data`, output, `4*NIB`: payload. The first received nibble lands in the most significant nibble.
- `err`, output, 1: one-cycle pulse when a frame is rejected for a bad tag.

## Operation
State machine, enum `{IDLE, PAYLOAD, HOLD}`.

Header format:
- Bit 3 is the sync bit and must be 1.
- Bits 2:0 carry the tag.

IDLE:
- `in_ready=1`.
- Accepted nibble with bit 3 = 0: discarded silently, stay in IDLE, no `err`.
- Accepted nibble with bit 3 = 1 and tag in {2,3,4}: latch the tag, clear the nibble counter, go to PAYLOAD.
- Accepted nibble with bit 3 = 1 and tag outside {2,3,4}: pulse `err` for 1 cycle, stay in IDLE.

PAYLOAD:
- `in_ready=1`.
- Each accepted nibble shifts into the payload register: `data <= {data[4*NIB-5:0], in_data}`. The counter increments.
- When the `NIB`-th nibble is accepted, go to HOLD.
- A nibble with bit 3 set is treated as payload here, never as a header.

HOLD:
- `out_valid=1`. `out_tag` and `out_data` stay stable until the output transfer.
- On `out_ready`, leave HOLD:
  - If a header nibble is accepted in the same cycle, go directly to PAYLOAD with the new tag.
  - Otherwise go to IDLE.

Signal rules:
- `in_ready = (state != HOLD) || out_ready`. This allows back-to-back frames with no bubble.
- `out_data` and `out_tag` are only meaningful while `out_valid=1`. They hold their last values otherwise.
- Nibble counter width is `$clog2(NIB+1)`. It never wraps: it is cleared on each header.
- `in_valid=0` during PAYLOAD stalls the frame indefinitely. There is no timeout.

## Timing
- Reset values: state=IDLE, `in_ready=1`, `out_valid=0`, `out_tag=0`, `out_data=0`, `err=0`, counter=0.
- Reset asserted mid-frame or in HOLD discards the partial or held frame. Outputs take their reset values the cycle after `rst` is sampled high.
- `rst` has priority over every simultaneous handshake.
- Latency: `out_valid` rises on the clock edge that accepts the last payload nibble, so it is visible the next cycle. A full frame takes `1+NIB` input transfers. Throughput is one frame per `1+NIB` cycles with `out_ready` held high.
- `err` is registered. It is high the cycle after the bad header is accepted.
- A single cycle never produces both `err` and a state change to PAYLOAD.

## Test plan
- **Basic frame:** reset, then send `NIB=4` frame `0xB,1,2,3,4` with `out_ready=1`.
  - `out_valid` is high for 1 cycle with `out_tag=3`, `out_data=16'h1234`.
  - `err` stays 0.
- **Backpressure:** hold `out_ready=0` after frame `0xA,F,0,0,D`.
  - `out_valid` stays high with `out_tag=2`, `out_data=16'hF00D`.
  - `in_ready=0` throughout.
  - Raise `out_ready` in the same cycle as header `0xC` → new frame accepted with no idle cycle; the next record has `out_tag=4`.
- **Bad tag and sync:** send `0x8` (tag 0), then `0x5` (no sync), then a valid frame `0xB,A,B,C,D`.
  - `err` pulses exactly once, for the `0x8` header.
  - `0x5` is dropped silently.
  - Record `out_tag=3`, `out_data=16'hABCD`.
- **Payload with bit 3 set:** frame `0xA,8,9,E,F`.
  - `out_data=16'h89EF`.
  - No `err`, no re-sync.
- **Input stall and reset mid-frame:**
  - Send `0xB,1,2`, deassert `in_valid` for 5 cycles, assert `rst` for 1 cycle.
  - All outputs return to reset values.
  - The next frame `0xC,5,6,7,8` yields `out_tag=4`, `out_data=16'h5678`; no residue from the aborted frame.
- **Parameter sweep:** `NIB=1` and `NIB=8`.
  - `NIB=1`, frame `0xA,7` → `out_data=4'h7`.
  - `NIB=8`, nibbles 1..8 → `out_data=32'h12345678`.
  - Back-to-back frames at full rate give one record every `1+NIB` cycles.
